// File: rtl/shiftreg_load_ctrl_pkg.sv
// Shared definitions for the shift-register load controller.
//   - default block byte counts (1056-bit and 6144-bit blocks)
//   - block-size encoding carried on in_blk_size / blk_size
//   - FSM state type
//   - counter width
package shiftreg_load_ctrl_pkg;

   localparam int unsigned BLK_SMALL_BYTES_DEF = 132;  // 1056 bits
   localparam int unsigned BLK_LARGE_BYTES_DEF = 768;  // 6144 bits
   localparam int unsigned CNT_W               = 10;

   typedef enum logic {
      BLK_1056 = 1'b0,
      BLK_6144 = 1'b1
   } blk_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/blk_byte_counter.sv
// Byte counter for the block currently being filled.
// Ports:
//   clk, aclr_n : clock, asynchronous active-low reset
//   clr         : synchronous clear to 0 (highest priority)
//   start       : load 1 (first byte of a block)
//   inc         : count one accepted byte; saturates at limit
//   limit       : block length N in bytes
//   at_last     : next counted byte makes count equal N
module blk_byte_counter
   import shiftreg_load_ctrl_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         aclr_n,
   input  logic         clr,
   input  logic         start,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         at_last
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (start) begin
         count <= W'(1);
      end else if (inc && (count != limit)) begin
         count <= count + W'(1);
      end
   end

   assign at_last = (count == (limit - W'(1)));

endmodule

// File: rtl/shiftreg_load_ctrl.sv
// Loads code-block bytes into an external 8-bit-wide shift register.
// Ports:
//   clk, aclr_n             : clock, asynchronous active-low reset
//   in_valid/in_data/in_sof : upstream byte stream, in_sof marks block start
//   in_blk_size             : block size, sampled with the SOF byte
//   in_ready                : byte accepted when in_valid && in_ready
//   flush                   : synchronous abort, back to IDLE
//   sr_shift_en/sr_shiftin  : one registered 8-bit shift per accepted byte
//   sr_clr                  : one-cycle clear of the shift register
//   blk_valid/blk_size      : complete block held, and its size
//   blk_ack                 : consumer has taken the block
//   sof_err                 : sticky, SOF seen while a block was filling
// On an SOF restart sr_clr and the new byte's sr_shift_en coincide; the
// shift register is expected to clear first and then take the byte.
module shiftreg_load_ctrl
   import shiftreg_load_ctrl_pkg::*;
#(
   parameter int unsigned BLK_SMALL_BYTES = BLK_SMALL_BYTES_DEF,
   parameter int unsigned BLK_LARGE_BYTES = BLK_LARGE_BYTES_DEF
) (
   input  logic       clk,
   input  logic       aclr_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_sof,
   input  logic       in_blk_size,
   output logic       in_ready,
   input  logic       flush,
   output logic       sr_shift_en,
   output logic [7:0] sr_shiftin,
   output logic       sr_clr,
   output logic       blk_valid,
   output logic       blk_size,
   input  logic       blk_ack,
   output logic       sof_err
);

   state_e           state_q, state_d;
   blk_size_e        size_q;
   logic             shift_q, shift_d;
   logic [7:0]       shiftin_q;
   logic             clr_q, clr_d;
   logic             bv_q, bv_d;
   logic             err_q, err_set;
   logic             size_ld;
   logic             cnt_clr, cnt_start, cnt_inc, at_last;
   logic             accept;
   logic [CNT_W-1:0] limit;

   assign in_ready = (state_q != ST_HOLD);
   assign accept   = in_valid && in_ready;
   assign limit    = (size_q == BLK_6144) ? CNT_W'(BLK_LARGE_BYTES)
                                          : CNT_W'(BLK_SMALL_BYTES);

   blk_byte_counter #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .aclr_n (aclr_n),
      .clr    (cnt_clr),
      .start  (cnt_start),
      .inc    (cnt_inc),
      .limit  (limit),
      .at_last(at_last)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = 1'b0;
      clr_d     = 1'b0;
      bv_d      = 1'b0;
      cnt_clr   = 1'b0;
      cnt_start = 1'b0;
      cnt_inc   = 1'b0;
      size_ld   = 1'b0;
      err_set   = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         clr_d   = 1'b1;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept && in_sof) begin
                  state_d   = ST_FILL;
                  shift_d   = 1'b1;
                  cnt_start = 1'b1;
                  size_ld   = 1'b1;
               end
            end
            ST_FILL: begin
               if (accept) begin
                  shift_d = 1'b1;
                  if (in_sof) begin
                     err_set   = 1'b1;
                     clr_d     = 1'b1;
                     cnt_start = 1'b1;
                     size_ld   = 1'b1;
                  end else begin
                     cnt_inc = 1'b1;
                     if (at_last) state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // blk_valid trails HOLD entry by a cycle; ack only counts once it is up
               if (blk_ack && bv_q) begin
                  state_d = ST_IDLE;
                  cnt_clr = 1'b1;
               end else begin
                  bv_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q   <= ST_IDLE;
         size_q    <= BLK_1056;
         shift_q   <= 1'b0;
         shiftin_q <= '0;
         clr_q     <= 1'b0;
         bv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         clr_q   <= clr_d;
         bv_q    <= bv_d;
         if (shift_d) shiftin_q <= in_data;
         if (size_ld) size_q <= blk_size_e'(in_blk_size);
         if (err_set) err_q <= 1'b1;
      end
   end

   // A flush also cancels the shift still pending from the previous cycle.
   assign sr_shift_en = shift_q && !flush;
   assign sr_shiftin  = shiftin_q;
   assign sr_clr      = clr_q;
   assign blk_valid   = bv_q;
   assign blk_size    = size_q;
   assign sof_err     = err_q;

endmodule

// File: tb/tb_shiftreg_load_ctrl.sv
module tb_shiftreg_load_ctrl;

   logic       clk = 1'b0;
   logic       aclr_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_sof = 1'b0;
   logic       in_blk_size = 1'b0;
   logic       in_ready;
   logic       flush = 1'b0;
   logic       sr_shift_en;
   logic [7:0] sr_shiftin;
   logic       sr_clr;
   logic       blk_valid;
   logic       blk_size;
   logic       blk_ack = 1'b0;
   logic       sof_err;

   int total = 0;
   int bad   = 0;

   shiftreg_load_ctrl #(.BLK_SMALL_BYTES(132), .BLK_LARGE_BYTES(768)) dut (
      .clk        (clk),
      .aclr_n     (aclr_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .in_blk_size(in_blk_size),
      .in_ready   (in_ready),
      .flush      (flush),
      .sr_shift_en(sr_shift_en),
      .sr_shiftin (sr_shiftin),
      .sr_clr     (sr_clr),
      .blk_valid  (blk_valid),
      .blk_size   (blk_size),
      .blk_ack    (blk_ack),
      .sof_err    (sof_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int blk_bytes(input bit sz);
      return sz ? 768 : 132;
   endfunction

   // ---------------- behavioural reference ----------------
   // m_mode: 0 waiting for SOF, 1 collecting, 2 block complete
   int        m_mode = 0;
   int        m_cnt  = 0;
   bit        m_size = 0;
   bit        m_err  = 0;
   bit        m_pend = 0;
   bit [7:0]  m_shin = 0;
   bit        m_clr  = 0;
   bit        m_bv   = 0;
   byte unsigned m_blk[$];

   always @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         m_mode <= 0; m_cnt <= 0; m_size <= 0; m_err <= 0;
         m_pend <= 0; m_shin <= 0; m_clr <= 0; m_bv <= 0;
         m_blk.delete();
      end else begin
         bit acc, p, c, st;
         acc = in_valid && (m_mode != 2);
         p = 0; c = 0; st = 0;
         m_bv <= !flush && (m_mode == 2) && !(blk_ack && m_bv);
         if (flush) begin
            m_mode <= 0; m_cnt <= 0; c = 1;
            m_blk.delete();
         end else if (m_mode == 0) begin
            if (acc && in_sof) begin st = 1; m_mode <= 1; end
         end else if (m_mode == 1) begin
            if (acc && in_sof) begin
               st = 1; c = 1; m_err <= 1;
            end else if (acc) begin
               p = 1;
               m_cnt <= m_cnt + 1;
               m_blk.push_back(in_data);
               if (m_cnt + 1 == blk_bytes(m_size)) m_mode <= 2;
            end
         end else begin
            if (blk_ack && m_bv) begin m_mode <= 0; m_cnt <= 0; end
         end
         if (st) begin
            p = 1;
            m_cnt <= 1;
            m_size <= in_blk_size;
            m_blk.delete();
            m_blk.push_back(in_data);
         end
         m_pend <= p;
         m_clr  <= c;
         if (p) m_shin <= in_data;
      end
   end

   // ---------------- compare + observed register image ----------------
   bit chk_on = 0;
   bit prev_bv = 0;
   byte unsigned sr_img[$];
   int n_shift = 0;
   int n_clr   = 0;
   int n_bv    = 0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("in_ready",    in_ready,    m_mode != 2);
         chk("sr_shift_en", sr_shift_en, m_pend && !flush);
         chk("sr_shiftin",  sr_shiftin,  m_shin);
         chk("sr_clr",      sr_clr,      m_clr);
         chk("blk_valid",   blk_valid,   m_bv);
         chk("blk_size",    blk_size,    m_size);
         chk("sof_err",     sof_err,     m_err);
      end
      if (!aclr_n) sr_img.delete();
      if (sr_clr) sr_img.delete();
      if (sr_shift_en) begin
         sr_img.push_back(sr_shiftin);
         if (sr_img.size() > 768) void'(sr_img.pop_front());
         n_shift++;
      end
      if (sr_clr) n_clr++;
      if (blk_valid) n_bv++;
      if (chk_on && blk_valid && !prev_bv) begin
         bit eq;
         int off;
         eq = (sr_img.size() >= m_blk.size());
         off = sr_img.size() - m_blk.size();
         if (eq) foreach (m_blk[i]) if (sr_img[off + i] != m_blk[i]) eq = 0;
         chk("blk_contents", eq, 1);
      end
      prev_bv = blk_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input bit v, input logic [7:0] d, input bit s, input bit z,
                      input bit f, input bit a);
      @(posedge clk); #2;
      in_valid = v; in_data = d; in_sof = s; in_blk_size = z; flush = f; blk_ack = a;
   endtask

   task automatic idle_cyc();
      drv(0, 8'h00, 0, 0, 0, 0);
      @(negedge clk); #1;
   endtask

   task automatic wait_bv(input int maxc);
      bit ok;
      ok = 0;
      for (int i = 0; i < maxc && !ok; i++) begin
         idle_cyc();
         if (blk_valid) ok = 1;
      end
      chk("blk_valid_timeout", ok, 1);
   endtask

   task automatic send_bytes(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) while ($urandom_range(0, 2) == 0) drv(0, 8'h00, 0, 0, 0, 0);
         drv(1, 8'($urandom), 0, 0, 0, 0);
      end
   endtask

   task automatic ack_block();
      drv(0, 8'h00, 0, 0, 0, 1);
      @(negedge clk); #1;
      chk("bv_during_ack", blk_valid, 1);
      idle_cyc();
      chk("bv_after_ack", blk_valid, 0);
      chk("ready_after_ack", in_ready, 1);
   endtask

   initial begin
      int s0, c0, b0;
      // reset values
      #12;
      chk("rst_shift_en", sr_shift_en, 0);
      chk("rst_shiftin",  sr_shiftin,  0);
      chk("rst_clr",      sr_clr,      0);
      chk("rst_bv",       blk_valid,   0);
      chk("rst_size",     blk_size,    0);
      chk("rst_err",      sof_err,     0);
      chk("rst_ready",    in_ready,    1);
      @(posedge clk); #2; aclr_n = 1'b1;
      chk_on = 1;

      // small block, back-to-back
      @(negedge clk); #1;
      s0 = n_shift;
      drv(1, 8'h5A, 1, 0, 0, 0);
      send_bytes(131, 0);
      idle_cyc();
      chk("small_last_shift", sr_shift_en, 1);
      chk("small_bv_early", blk_valid, 0);
      chk("small_ready_hold", in_ready, 0);
      idle_cyc();
      chk("small_bv", blk_valid, 1);
      chk("small_size", blk_size, 0);
      chk("small_ready", in_ready, 0);
      chk("small_shifts", n_shift - s0, 132);
      chk("small_err", sof_err, 0);
      ack_block();

      // large block with gaps, held 5 cycles
      s0 = n_shift;
      drv(1, 8'hC3, 1, 1, 0, 0);
      send_bytes(767, 1);
      wait_bv(4);
      chk("large_size", blk_size, 1);
      for (int i = 0; i < 4; i++) begin
         idle_cyc();
         chk("large_hold", blk_valid, 1);
      end
      chk("large_shifts", n_shift - s0, 768);
      ack_block();

      // non-SOF bytes dropped in IDLE
      s0 = n_shift;
      for (int i = 0; i < 3; i++) drv(1, 8'(i + 1), 0, 0, 0, 0);
      idle_cyc();
      idle_cyc();
      chk("idle_drop", n_shift - s0, 0);
      drv(1, 8'h11, 1, 0, 0, 0);
      send_bytes(130, 0);
      idle_cyc();
      idle_cyc();
      chk("drop_not_done", blk_valid, 0);
      send_bytes(1, 0);
      wait_bv(3);
      chk("drop_shifts", n_shift - s0, 132);
      ack_block();

      // SOF at byte 50
      drv(1, 8'h22, 1, 0, 0, 0);
      send_bytes(48, 0);
      drv(1, 8'h33, 1, 0, 0, 0);
      @(negedge clk); #1;
      chk("sof50_err_pre", sof_err, 0);
      s0 = n_shift;
      c0 = n_clr;
      send_bytes(1, 0);
      @(negedge clk); #1;
      chk("sof50_clr", sr_clr, 1);
      chk("sof50_err", sof_err, 1);
      send_bytes(130, 0);
      wait_bv(3);
      chk("sof50_shifts", n_shift - s0, 132);
      chk("sof50_clrs", n_clr - c0, 1);
      ack_block();

      // flush at byte 400 of a large fill
      b0 = n_bv;
      drv(1, 8'h44, 1, 1, 0, 0);
      send_bytes(398, 0);
      drv(1, 8'h99, 0, 0, 1, 0);
      @(negedge clk); #1;
      chk("flush_noshift", sr_shift_en, 0);
      idle_cyc();
      chk("flush_clr", sr_clr, 1);
      chk("flush_noshift2", sr_shift_en, 0);
      idle_cyc();
      chk("flush_clr_end", sr_clr, 0);
      for (int i = 0; i < 8; i++) idle_cyc();
      chk("flush_no_bv", n_bv - b0, 0);
      chk("flush_ready", in_ready, 1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         drv($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) == 0,
             1'($urandom), $urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0);
      end
      drv(0, 8'h00, 0, 0, 1, 0);
      idle_cyc();

      // async reset during HOLD
      drv(1, 8'h66, 1, 0, 0, 0);
      send_bytes(131, 0);
      wait_bv(3);
      @(posedge clk); #3;
      aclr_n = 1'b0;
      #1;
      chk("arst_bv",    blk_valid,   0);
      chk("arst_shift", sr_shift_en, 0);
      chk("arst_in",    sr_shiftin,  0);
      chk("arst_clr",   sr_clr,      0);
      chk("arst_size",  blk_size,    0);
      chk("arst_err",   sof_err,     0);
      chk("arst_ready", in_ready,    1);
      @(posedge clk); #2; aclr_n = 1'b1;
      idle_cyc();
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_bv", blk_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
